// File: rtl/mmio_byte_if.sv
// Byte-stream and MMIO bus signals of the byte-driven MMIO initiator.
// The master modport is the initiator side; slave is its environment (UART core + MMIO controller).
interface mmio_byte_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mmio_cs;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, mmio_rd_data,
    output tx_data, tx_valid, mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output busy, timeout_err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mmio_rd_data,
    input  tx_data, tx_valid, mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  busy, timeout_err
  );
endinterface

// File: rtl/mmio_byte_master.sv
// Parses 'W'/'R' host frames from a byte stream, issues one MMIO bus cycle per frame and
// returns 'K', the 4 read bytes, or '?' for an unknown opcode.
module mmio_byte_master #(
  parameter int unsigned TimeoutCyc = 1_000_000
) (
  input logic         clk_i,
  input logic         rst_ni,
  mmio_byte_if.master bus
);

  localparam int unsigned    TmoW    = $clog2(TimeoutCyc + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCyc - 1);
  localparam logic [7:0]     OpWrite = 8'h57;
  localparam logic [7:0]     OpRead  = 8'h52;
  localparam logic [7:0]     RspAck  = 8'h4B;
  localparam logic [7:0]     RspErr  = 8'h3F;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [20:0]       addr_sh_q, addr_sh_d;
  logic [31:0]       data_sh_q, data_sh_d;
  logic [31:0]       resp_q, resp_d;
  logic [20:0]       mmio_addr_q, mmio_addr_d;
  logic [31:0]       mmio_wr_data_q, mmio_wr_data_d;
  logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              tmo_err_q, tmo_err_d;
  logic              tmo_hit;
  logic              tx_hs;

  assign tx_hs = tx_valid_q & bus.tx_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == OpWrite || bus.rx_data == OpRead) begin
            state_d = StAddr;
          end else begin
            state_d = StResp;
          end
        end
      end
      StAddr: begin
        if (bus.rx_valid) begin
          if (cnt_q == 3'd2) begin
            state_d = is_wr_q ? StData : StBus;
          end
        end else if (tmo_q == TmoLast) begin
          tmo_hit = 1'b1;
          state_d = StIdle;
        end
      end
      StData: begin
        if (bus.rx_valid) begin
          if (cnt_q == 3'd3) begin
            state_d = StBus;
          end
        end else if (tmo_q == TmoLast) begin
          tmo_hit = 1'b1;
          state_d = StIdle;
        end
      end
      StBus: state_d = StResp;
      StResp: begin
        if (tx_hs && cnt_q == 3'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state: frame shift registers, byte/idle counters and the response shifter.
  always_comb begin
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    resp_d    = resp_q;
    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == OpWrite || bus.rx_data == OpRead) begin
            is_wr_d = (bus.rx_data == OpWrite);
            cnt_d   = 3'd0;
          end else begin
            resp_d = {RspErr, 24'h0};
            cnt_d  = 3'd1;
          end
        end
      end
      StAddr: begin
        if (bus.rx_valid) begin
          // Only 21 bits are kept, so the top 3 bits of the first address byte fall off.
          addr_sh_d = {addr_sh_q[12:0], bus.rx_data};
          cnt_d     = (cnt_q == 3'd2) ? 3'd0 : cnt_q + 3'd1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StData: begin
        if (bus.rx_valid) begin
          data_sh_d = {data_sh_q[23:0], bus.rx_data};
          cnt_d     = cnt_q + 3'd1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StBus: begin
        resp_d = is_wr_q ? {RspAck, 24'h0} : bus.mmio_rd_data;
        cnt_d  = is_wr_q ? 3'd1 : 3'd4;
      end
      StResp: begin
        if (tx_hs) begin
          resp_d = {resp_q[23:0], 8'h0};
          cnt_d  = cnt_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs are derived from the upcoming state so they line up with it.
  always_comb begin
    cs_d           = (state_d == StBus);
    wr_d           = cs_d & is_wr_q;
    rd_d           = cs_d & ~is_wr_q;
    tx_valid_d     = (state_d == StResp);
    busy_d         = (state_d != StIdle);
    tmo_err_d      = tmo_hit;
    mmio_addr_d    = mmio_addr_q;
    mmio_wr_data_d = mmio_wr_data_q;
    if (cs_d) begin
      mmio_addr_d = addr_sh_d;
      if (is_wr_q) begin
        mmio_wr_data_d = data_sh_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      is_wr_q        <= 1'b0;
      cnt_q          <= '0;
      tmo_q          <= '0;
      addr_sh_q      <= '0;
      data_sh_q      <= '0;
      resp_q         <= '0;
      mmio_addr_q    <= '0;
      mmio_wr_data_q <= '0;
      cs_q           <= 1'b0;
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      tx_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      tmo_err_q      <= 1'b0;
    end else begin
      is_wr_q        <= is_wr_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      addr_sh_q      <= addr_sh_d;
      data_sh_q      <= data_sh_d;
      resp_q         <= resp_d;
      mmio_addr_q    <= mmio_addr_d;
      mmio_wr_data_q <= mmio_wr_data_d;
      cs_q           <= cs_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      tx_valid_q     <= tx_valid_d;
      busy_q         <= busy_d;
      tmo_err_q      <= tmo_err_d;
    end
  end

  assign bus.tx_data      = resp_q[31:24];
  assign bus.tx_valid     = tx_valid_q;
  assign bus.mmio_cs      = cs_q;
  assign bus.mmio_wr      = wr_q;
  assign bus.mmio_rd      = rd_q;
  assign bus.mmio_addr    = mmio_addr_q;
  assign bus.mmio_wr_data = mmio_wr_data_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = tmo_err_q;

endmodule
